uart_tx: RTL and testbench

//  UART transmitter; the transmit counterpart to the RX path (edge_bit_counter/data_sampling).

---
 rtl/uart_tx_pkg.sv | 30 +++
 rtl/uart_tx_if.sv | 26 ++
 rtl/uart_tx_bit_timer.sv | 54 +++++
 rtl/uart_tx.sv | 120 ++++++++++++
 tb/tb_uart_tx.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART types: FSM state encoding, parity-type constants and the parity helper.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package uart_tx_pkg;

  // One state encoding for both the TX and RX FSMs.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // data_xor is the XOR-reduction of the payload.
  // Even parity sends it unchanged; odd parity sends its inverse.
  function automatic logic parity_bit(input logic data_xor, input logic par_typ);
    logic r;
    case (par_typ)
      PAR_EVEN: r = data_xor;
      PAR_ODD:  r = ~data_xor;
      default:  r = data_xor;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-side bus of the UART transmitter: request and frame settings in, line and busy out.
// Latency: n/a (signal bundle only).
// Backpressure: data_valid is only taken while busy is low; requests made while busy are dropped.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 5
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [PRESC_W-1:0]    prescale;
  logic                  TX_OUT;
  logic                  busy;

  // master: whoever supplies bytes; slave: the transmitter.
  modport master (
    output P_DATA, data_valid, PAR_EN, PAR_TYP, prescale,
    input  TX_OUT, busy
  );

  modport slave (
    input  P_DATA, data_valid, PAR_EN, PAR_TYP, prescale,
    output TX_OUT, busy
  );
endinterface

// File: rtl/uart_tx_bit_timer.sv
// Bit timer: edge counter inside a bit plus the data-bit index, prescale latched per frame.
// Latency: bit_done is combinational, high in the last clk cycle of each bit.
// Backpressure: none; it counts whenever en_i is high.
// Ports: clk/rst; load_i (frame accept: latch presc_i, clear counters); en_i (frame active);
//        data_phase_i (advance bit_cnt on bit_done); bit_done_o; bit_cnt_o.
module uart_tx_bit_timer #(
  parameter int PRESC_W = 5,
  parameter int BIT_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  logic               en_i,
  input  logic               data_phase_i,
  output logic               bit_done_o,
  output logic [BIT_W-1:0]   bit_cnt_o
);

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] edge_cnt_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [PRESC_W-1:0] last_edge;

  // Modular subtraction: prescale 0 gives an all-ones terminal count,
  // so a bit lasts 2**PRESC_W cycles with no special case.
  assign last_edge  = presc_q - PRESC_W'(1);
  assign bit_done_o = en_i && (edge_cnt_q == last_edge);
  assign bit_cnt_o  = bit_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q    <= '0;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else if (load_i) begin
      presc_q    <= presc_i;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else if (en_i) begin
      if (bit_done_o) begin
        edge_cnt_q <= '0;
        // bit_cnt only walks through the payload; any other bit leaves it at 0.
        bit_cnt_q  <= data_phase_i ? bit_cnt_q + BIT_W'(1) : '0;
      end else begin
        edge_cnt_q <= edge_cnt_q + PRESC_W'(1);
      end
    end else begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_WIDTH bits LSB-first, optional parity, stop; each bit lasts prescale clk cycles.
// Latency: TX_OUT drops to the start bit on the accept edge; busy falls (DATA_WIDTH+2+PAR_EN)*P cycles later.
// Backpressure: data_valid is accepted only in IDLE (busy low); requests while busy are ignored, not queued.
// Ports: clk, rst (async active-low); bus (slave modport): P_DATA, data_valid, PAR_EN, PAR_TYP,
//        prescale in; TX_OUT (registered, idles high), busy (registered) out.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 5
) (
  input logic       clk,
  input logic       rst,
  uart_tx_if.slave  bus
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  uart_state_e           state_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  tx_q;
  logic                  busy_q;

  logic                  accept;
  logic                  bit_done;
  logic [BIT_W-1:0]      bit_cnt;
  logic [BIT_W-1:0]      bit_nxt;
  logic                  par_bit;

  assign accept  = (state_q == ST_IDLE) && bus.data_valid;
  assign bit_nxt = bit_cnt + BIT_W'(1);
  assign par_bit = parity_bit(^data_q, par_typ_q);

  uart_tx_bit_timer #(
    .PRESC_W (PRESC_W),
    .BIT_W   (BIT_W)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .load_i       (accept),
    .presc_i      (bus.prescale),
    .en_i         (state_q != ST_IDLE),
    .data_phase_i (state_q == ST_DATA),
    .bit_done_o   (bit_done),
    .bit_cnt_o    (bit_cnt)
  );

  // TX_OUT is registered, so every transition loads the level of the bit
  // that starts on that same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (bus.data_valid) begin
            data_q    <= bus.P_DATA;
            par_en_q  <= bus.PAR_EN;
            par_typ_q <= bus.PAR_TYP;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_done) begin
            tx_q    <= data_q[0];
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            if (bit_cnt == LAST_BIT) begin
              if (par_en_q) begin
                tx_q    <= par_bit;
                state_q <= ST_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= ST_STOP;
              end
            end else begin
              tx_q <= data_q[bit_nxt];
            end
          end
        end
        ST_PARITY: begin
          if (bit_done) begin
            tx_q    <= 1'b1;
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.TX_OUT = tx_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level reference model checked every cycle, plus a mid-bit sampling receiver
// compared against hand-computed frame images and busy durations.
// Latency/backpressure: n/a (testbench).
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_if #(.DATA_WIDTH(8), .PRESC_W(5)) u_if ();

  uart_tx #(.DATA_WIDTH(8), .PRESC_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: on an accepted request, the expected line is a list of
  // bit levels, each held for P cycles; busy covers the whole list.
  bit   m_active = 1'b0;
  int   m_k = 0;
  int   m_p = 1;
  logic m_bits[$];

  initial begin
    logic e_tx, e_busy;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_active = 1'b0;
      end else if (m_active) begin
        m_k++;
        if (m_k >= m_bits.size() * m_p) m_active = 1'b0;
      end else if (u_if.data_valid) begin
        m_p = (u_if.prescale == 5'd0) ? 32 : int'(u_if.prescale);
        m_bits = {};
        m_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) m_bits.push_back(u_if.P_DATA[i]);
        if (u_if.PAR_EN) m_bits.push_back((^u_if.P_DATA) ^ u_if.PAR_TYP);
        m_bits.push_back(1'b1);
        m_k = 0;
        m_active = 1'b1;
      end
      @(negedge clk);
      if (!rst || !m_active) begin
        e_tx = 1'b1;
        e_busy = 1'b0;
      end else begin
        e_tx = m_bits[m_k / m_p];
        e_busy = 1'b1;
      end
      chk("cyc_tx", 32'(u_if.TX_OUT), 32'(e_tx));
      chk("cyc_busy", 32'(u_if.busy), 32'(e_busy));
      if (!u_if.busy) chk("idle_line_high", 32'(u_if.TX_OUT), 32'd1);
    end
  end

  // Drive a one-cycle request; returns at the negedge just after the accept edge.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [4:0] ps);
    @(negedge clk);
    u_if.P_DATA     = d;
    u_if.PAR_EN     = pe;
    u_if.PAR_TYP    = pt;
    u_if.prescale   = ps;
    u_if.data_valid = 1'b1;
    @(negedge clk);
    u_if.data_valid = 1'b0;
  endtask

  // Receiver: called at the negedge after the accept edge. Samples each bit at
  // mid-bit, counts busy cycles, returns at the first negedge with busy low.
  task automatic rx_frame(input int p, input int nb, output logic [15:0] bits, output int busy_cyc);
    int k;
    k = 0;
    bits = '0;
    busy_cyc = 0;
    forever begin
      if (u_if.busy) busy_cyc++;
      if ((k % p) == (p / 2) && (k / p) < nb) bits[k / p] = u_if.TX_OUT;
      if (k > 0 && !u_if.busy) break;
      if (k >= nb * p + 8) begin
        checks++;
        failures++;
        $display("FAIL rx_timeout busy still high after %0d cycles, limit %0d", k, nb * p + 8);
        break;
      end
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] b;
    int          c;
    rst = 1'b0;
    u_if.data_valid = 1'b0;
    u_if.P_DATA     = 8'h00;
    u_if.PAR_EN     = 1'b0;
    u_if.PAR_TYP    = 1'b0;
    u_if.prescale   = 5'd8;

    // 1: requests during reset are ignored
    repeat (2) @(negedge clk);
    u_if.data_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_rst_tx", 32'(u_if.TX_OUT), 32'd1);
    chk("t1_rst_busy", 32'(u_if.busy), 32'd0);
    u_if.data_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("t1_post_busy", 32'(u_if.busy), 32'd0);
    chk("t1_post_tx", 32'(u_if.TX_OUT), 32'd1);

    // 2: P=8, no parity, 0xA5
    send(8'hA5, 1'b0, 1'b0, 5'd8);
    rx_frame(8, 10, b, c);
    chk("t2_bits", 32'(b), 32'h034A);
    chk("t2_busy", 32'(c), 32'd80);

    // 3: P=16 with even then odd parity
    send(8'hA5, 1'b1, 1'b0, 5'd16);
    rx_frame(16, 11, b, c);
    chk("t3_even_bits", 32'(b), 32'h054A);
    chk("t3_even_busy", 32'(c), 32'd176);
    send(8'hA5, 1'b1, 1'b1, 5'd16);
    rx_frame(16, 11, b, c);
    chk("t3_odd_bits", 32'(b), 32'h074A);
    chk("t3_odd_busy", 32'(c), 32'd176);

    // 4: data_valid held high, back-to-back frames
    @(negedge clk);
    u_if.P_DATA     = 8'h00;
    u_if.PAR_EN     = 1'b0;
    u_if.prescale   = 5'd8;
    u_if.data_valid = 1'b1;
    @(negedge clk);
    u_if.P_DATA = 8'hFF;
    rx_frame(8, 10, b, c);
    chk("t4_f1_bits", 32'(b), 32'h0200);
    chk("t4_f1_busy", 32'(c), 32'd80);
    chk("t4_gap_idle", 32'(u_if.busy), 32'd0);
    @(negedge clk);
    chk("t4_restart", 32'(u_if.busy), 32'd1);
    rx_frame(8, 10, b, c);
    u_if.data_valid = 1'b0;
    chk("t4_f2_bits", 32'(b), 32'h03FE);
    chk("t4_f2_busy", 32'(c), 32'd80);

    // 5: prescale 0 => 32 cycles per bit; mid-frame prescale change ignored
    send(8'h01, 1'b0, 1'b0, 5'd0);
    rx_frame(32, 10, b, c);
    chk("t5_p32_bits", 32'(b), 32'h0202);
    chk("t5_p32_busy", 32'(c), 32'd320);
    send(8'hC3, 1'b0, 1'b0, 5'd8);
    fork
      rx_frame(8, 10, b, c);
      begin
        repeat (20) @(negedge clk);
        #2 u_if.prescale = 5'd16;
      end
    join
    chk("t5_chg_bits", 32'(b), 32'h0386);
    chk("t5_chg_busy", 32'(c), 32'd80);

    // 6: reset during data bit 3 (bit 3 of 0xA5 is 0), then a clean frame
    send(8'hA5, 1'b0, 1'b0, 5'd8);
    repeat (35) @(negedge clk);
    chk("t6_pre_tx", 32'(u_if.TX_OUT), 32'd0);
    chk("t6_pre_busy", 32'(u_if.busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_abort_tx", 32'(u_if.TX_OUT), 32'd1);
    chk("t6_abort_busy", 32'(u_if.busy), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    send(8'h5A, 1'b1, 1'b1, 5'd8);
    rx_frame(8, 11, b, c);
    chk("t6_new_bits", 32'(b), 32'h06B4);
    chk("t6_new_busy", 32'(c), 32'd88);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
